// File: rtl/imem_loader.sv
// Serial byte loader that fills the instruction memory and holds the CPU.
// Optional checksum byte support: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WR, S_CHK, S_DONE
    } state_t;
    localparam state_t S_END = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WR, S_DONE
    } state_t;
    localparam state_t S_END = S_DONE;
`endif

    localparam logic [ADDR_W:0]   R_ONE = 1;
    localparam logic [ADDR_W-1:0] A_ONE = 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_rem;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [ADDR_W:0]     w_cnt;
    logic                w_ready;
    logic                w_we;
    logic                w_busy;
    logic                w_done;
    logic                w_load;
    logic                w_xfer;

    // count of zero stands for a full 2^ADDR_W word image
    assign w_cnt  = (count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                  : {1'b0, count};
    assign w_xfer = byte_valid & w_ready;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // next-state and handshake/status decode
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_load  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_HI;
                    w_load = 1'b1;
                end
            end
            S_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (byte_valid) w_next = S_LO;
            end
            S_LO: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (byte_valid) w_next = S_WR;
            end
            S_WR: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (r_rem == R_ONE) w_next = S_END;
                else                w_next = S_HI;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (byte_valid) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_next = S_HI;
                    w_load = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // word assembly, write address and remaining-word counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_load) begin
                r_rem  <= w_cnt;
                r_addr <= '0;
            end
            if (w_xfer && r_state == S_HI) r_wdata[15:8] <= byte_in;
            if (w_xfer && r_state == S_LO) r_wdata[7:0]  <= byte_in;
            if (r_state == S_WR) begin
                r_addr <= r_addr + A_ONE;
                r_rem  <= r_rem - R_ONE;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;

    // xor of program bytes, compared against the trailing check byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_csum <= '0;
                r_err  <= 1'b0;
            end
            if (w_xfer && (r_state == S_HI || r_state == S_LO))
                r_csum <= r_csum ^ byte_in;
            if (w_xfer && r_state == S_CHK)
                r_err <= (byte_in != r_csum);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign byte_ready = w_ready;
    assign im_we      = w_we;
    assign im_addr    = r_addr;
    assign im_wdata   = r_wdata;
    assign busy       = w_busy;
    assign cpu_hold   = w_busy;
    assign done       = w_done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Checksum cases follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int AW = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] count = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [15:0]   im_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad = 0;

    logic [7:0]    bq[$];
    logic [AW-1:0] wa[$];
    logic [15:0]   wd[$];
    logic [15:0]   mem [256];
    bit            hold_seen;
    bit            hold_bad;
    bit            rdy_wr_bad;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
            mem[im_addr] = im_wdata;
            if (byte_ready) rdy_wr_bad = 1'b1;
        end
        if (cpu_hold) hold_seen = 1'b1;
        if (cpu_hold !== busy) hold_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        hold_seen = 1'b0;
        hold_bad = 1'b0;
        rdy_wr_bad = 1'b0;
    endtask

    task automatic add_ck(input logic [7:0] cb);
        if (CK != 0) bq.push_back(cb);
    endtask

    task automatic do_load(input logic [AW-1:0] cnt, input bit toggle,
                           input bit pulse, input int budget,
                           output int cycles, output bit d_after,
                           output bit tmo);
        int  idx;
        bit  w;
        idx = 0;
        start = 1'b1;
        count = cnt;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        d_after = done;
        while (!done && cycles < budget) begin
            start = (pulse && cycles == 3);
            if (pulse && cycles == 3) count = 8'h05;
            byte_valid = (idx < bq.size()) && (!toggle || cycles % 2 == 1);
            byte_in = (idx < bq.size()) ? bq[idx] : 8'h00;
            w = byte_valid && byte_ready;
            @(posedge clk); #1;
            cycles++;
            if (w) idx++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        tmo = !done;
    endtask

    initial begin
        int  cyc;
        bit  da;
        bit  tmo;
        int  errs;
        logic [7:0] x;
        logic [7:0] i8;

        #12;
        check("rst_ready", byte_ready, 0);
        check("rst_we", im_we, 0);
        check("rst_addr", im_addr, 0);
        check("rst_wdata", im_wdata, 0);
        check("rst_busy_hold", {busy, cpu_hold}, 0);
        check("rst_done_err", {done, err}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        // start with byte_valid already high must not eat a byte
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        @(posedge clk); #1;
        byte_valid = 1'b0;

        // basic two-word load, continuous valid
        bq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        add_ck(8'h40);
        clear_mon();
        do_load(8'd2, 1'b0, 1'b0, 40, cyc, da, tmo);
        check("b_tmo", tmo, 0);
        check("b_cycles", cyc, 7 + CK);
        check("b_nwr", wa.size(), 2);
        check("b_w0", {wa[0], wd[0]}, {8'h00, 16'h1234});
        check("b_w1", {wa[1], wd[1]}, {8'h01, 16'hABCD});
        check("b_done", done, 1);
        check("b_hold", {hold_seen, cpu_hold, busy}, 3'b100);
        check("b_holdeq", hold_bad, 0);
        check("b_addr", im_addr, 2);
        check("b_err", err, 0);

        // reload from DONE with valid toggling
        clear_mon();
        do_load(8'd2, 1'b1, 1'b0, 60, cyc, da, tmo);
        check("t_tmo", tmo, 0);
        check("t_done_drop", da, 0);
        check("t_nwr", wa.size(), 2);
        check("t_w0", {wa[0], wd[0]}, {8'h00, 16'h1234});
        check("t_w1", {wa[1], wd[1]}, {8'h01, 16'hABCD});
        check("t_rdy_wr", rdy_wr_bad, 0);
        check("t_err", err, 0);

        // full image: count 0 means 256 words
        bq.delete();
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            i8 = i[7:0];
            bq.push_back(i8);
            bq.push_back(i8 ^ 8'hA5);
            x = x ^ 8'hA5;
        end
        add_ck(x);
        clear_mon();
        do_load(8'd0, 1'b0, 1'b0, 2000, cyc, da, tmo);
        check("f_tmo", tmo, 0);
        check("f_nwr", wa.size(), 256);
        errs = 0;
        for (int i = 0; i < 256 && i < wa.size(); i++) begin
            i8 = i[7:0];
            if (wa[i] !== i8 || wd[i] !== {i8, i8 ^ 8'hA5}) errs++;
        end
        check("f_words", errs, 0);
        check("f_addr_wrap", im_addr, 0);
        check("f_done", done, 1);

        // reset in the middle of a load
        clear_mon();
        start = 1'b1;
        count = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'h77;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("r_outs", {byte_ready, im_we, busy, cpu_hold, done, err}, 0);
        check("r_addr_data", {im_addr, im_wdata}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("r_nowe", wa.size(), 0);
        check("r_mem1", mem[1], {8'h01, 8'h01 ^ 8'hA5});
        bq = '{8'h55, 8'h66};
        add_ck(8'h33);
        do_load(8'd1, 1'b0, 1'b0, 40, cyc, da, tmo);
        check("r_tmo", tmo, 0);
        check("r_nwr", wa.size(), 1);
        check("r_w0", {wa[0], wd[0]}, {8'h00, 16'h5566});
        check("r_mem1b", mem[1], {8'h01, 8'h01 ^ 8'hA5});

        // start and count changes while busy are ignored
        bq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        add_ck(8'h40);
        clear_mon();
        do_load(8'd2, 1'b0, 1'b1, 60, cyc, da, tmo);
        check("i_tmo", tmo, 0);
        check("i_nwr", wa.size(), 2);
        check("i_cycles", cyc, 7 + CK);
        check("i_w1", {wa[1], wd[1]}, {8'h01, 16'hABCD});
        repeat (4) @(posedge clk);
        #1;
        check("i_still_done", {done, busy}, 2'b10);

`ifdef IMEM_LOADER_CHECKSUM_EN
        bq = '{8'h12, 8'h34, 8'h26};
        clear_mon();
        do_load(8'd1, 1'b0, 1'b0, 40, cyc, da, tmo);
        check("c_ok_tmo", tmo, 0);
        check("c_ok_err", err, 0);
        check("c_ok_w0", {wa[0], wd[0]}, {8'h00, 16'h1234});
        bq = '{8'h12, 8'h34, 8'h27};
        do_load(8'd1, 1'b0, 1'b0, 40, cyc, da, tmo);
        check("c_bad_err", err, 1);
        repeat (3) @(posedge clk);
        #1;
        check("c_err_hold", err, 1);
`else
        bq = '{8'h12, 8'h34};
        clear_mon();
        do_load(8'd1, 1'b0, 1'b0, 40, cyc, da, tmo);
        check("c_tmo", tmo, 0);
        check("c_cycles", cyc, 4);
        check("c_err", err, 0);
        check("c_w0", {wa[0], wd[0]}, {8'h00, 16'h1234});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
